// File: rtl/sram_like_arbiter.sv
// N-channel arbiter for the SRAM-like req/addr_ok/data_ok bus.
// Accepted requests are tagged in an in-order FIFO so each response returns to its issuing channel.
module sram_like_arbiter #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_CH-1:0]            m_req,
    input  logic [N_CH-1:0]            m_wr,
    input  logic [2*N_CH-1:0]          m_size,
    input  logic [4*N_CH-1:0]          m_wstrb,
    input  logic [32*N_CH-1:0]         m_addr,
    input  logic [32*N_CH-1:0]         m_wdata,
    output logic [N_CH-1:0]            m_addr_ok,
    output logic [N_CH-1:0]            m_data_ok,
    output logic [31:0]                m_rdata,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [3:0]                 s_wstrb,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,
    input  logic [31:0]                s_rdata,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err_unexp
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = $clog2(N_CH);

    logic [TAG_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic [TAG_W-1:0] lock_ch_q, lock_ch_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_q;

    logic [TAG_W-1:0] grant_c;
    logic [TAG_W-1:0] head_c;
    logic             full_c, empty_c, push_c, pop_c;

    assign full_c  = (cnt_q == CNT_W'(DEPTH));
    assign empty_c = (cnt_q == '0);
    assign s_req   = (|m_req) & ~full_c;
    assign push_c  = s_req & s_addr_ok;
    assign pop_c   = s_data_ok & ~empty_c;
    assign head_c  = fifo_q[rd_ptr_q];

    // Grant: a stalled request keeps its channel until accepted.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_c = '0;
        found   = 1'b0;
        idx     = 0;
        if (lock_q) begin
            grant_c = lock_ch_q;
        end else if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (m_req[i]) grant_c = TAG_W'(i);
            end
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!found && m_req[idx]) begin
                    found   = 1'b1;
                    grant_c = TAG_W'(idx);
                end
            end
        end
    end

    assign s_wr    = m_wr[grant_c];
    assign s_size  = m_size[2*32'(grant_c) +: 2];
    assign s_wstrb = m_wstrb[4*32'(grant_c) +: 4];
    assign s_addr  = m_addr[32*32'(grant_c) +: 32];
    assign s_wdata = m_wdata[32*32'(grant_c) +: 32];

    assign m_addr_ok   = push_c ? (N_CH'(1) << grant_c) : '0;
    assign m_data_ok   = pop_c  ? (N_CH'(1) << head_c)  : '0;
    assign m_rdata     = s_rdata;
    assign outstanding = cnt_q;
    assign err_unexp   = err_q;

    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        if (push_c) begin
            lock_d = 1'b0;
            if (ARB_MODE != 0)
                rr_ptr_d = (grant_c == TAG_W'(N_CH - 1)) ? '0 : grant_c + TAG_W'(1);
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_ch_d = grant_c;
        end
        if (push_c && !pop_c)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push_c && pop_c) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push_c) begin
                fifo_q[wr_ptr_q] <= grant_c;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (s_data_ok && empty_c) err_q <= 1'b1;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: fixed-priority 2-channel instance and round-robin 3-channel instance,
// with expected response routing tracked in scoreboard queues.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Instance A: N_CH=2, DEPTH=4, fixed priority
    logic [1:0]  a_m_req, a_m_wr, a_m_addr_ok, a_m_data_ok;
    logic [3:0]  a_m_size;
    logic [7:0]  a_m_wstrb;
    logic [63:0] a_m_addr, a_m_wdata;
    logic [31:0] a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
    logic        a_s_req, a_s_wr, a_s_addr_ok, a_s_data_ok, a_err;
    logic [1:0]  a_s_size;
    logic [3:0]  a_s_wstrb;
    logic [2:0]  a_out;

    // Instance B: N_CH=3, DEPTH=4, round-robin
    logic [2:0]  b_m_req, b_m_wr, b_m_addr_ok, b_m_data_ok;
    logic [5:0]  b_m_size;
    logic [11:0] b_m_wstrb;
    logic [95:0] b_m_addr, b_m_wdata;
    logic [31:0] b_m_rdata, b_s_addr, b_s_wdata, b_s_rdata;
    logic        b_s_req, b_s_wr, b_s_addr_ok, b_s_data_ok, b_err;
    logic [1:0]  b_s_size;
    logic [3:0]  b_s_wstrb;
    logic [2:0]  b_out;

    sram_like_arbiter #(.N_CH(2), .DEPTH(4), .ARB_MODE(0)) dut_a (
        .clk(clk), .resetn(resetn),
        .m_req(a_m_req), .m_wr(a_m_wr), .m_size(a_m_size), .m_wstrb(a_m_wstrb),
        .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_addr_ok(a_m_addr_ok), .m_data_ok(a_m_data_ok), .m_rdata(a_m_rdata),
        .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_wstrb(a_s_wstrb),
        .s_addr(a_s_addr), .s_wdata(a_s_wdata),
        .s_addr_ok(a_s_addr_ok), .s_data_ok(a_s_data_ok), .s_rdata(a_s_rdata),
        .outstanding(a_out), .err_unexp(a_err)
    );

    sram_like_arbiter #(.N_CH(3), .DEPTH(4), .ARB_MODE(1)) dut_b (
        .clk(clk), .resetn(resetn),
        .m_req(b_m_req), .m_wr(b_m_wr), .m_size(b_m_size), .m_wstrb(b_m_wstrb),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_addr_ok(b_m_addr_ok), .m_data_ok(b_m_data_ok), .m_rdata(b_m_rdata),
        .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_wstrb(b_s_wstrb),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata),
        .s_addr_ok(b_s_addr_ok), .s_data_ok(b_s_data_ok), .s_rdata(b_s_rdata),
        .outstanding(b_out), .err_unexp(b_err)
    );

    localparam logic [31:0] A0 = 32'h1000_0040;
    localparam logic [31:0] A1 = 32'h2000_0080;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] sb_a [$];
    logic [2:0] sb_b [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // One response cycle on A: expected channel comes from the scoreboard
    task automatic resp_a(input string tag, input logic [31:0] rd);
        logic [2:0] exp;
        a_s_data_ok = 1'b1;
        a_s_rdata   = rd;
        #1;
        exp = (sb_a.size() != 0) ? sb_a.pop_front() : 3'd0;
        chk(tag, a_m_data_ok, exp);
        chk({tag, "_rdata"}, a_m_rdata, rd);
    endtask

    task automatic resp_b(input string tag, input logic [31:0] rd);
        logic [2:0] exp;
        b_s_data_ok = 1'b1;
        b_s_rdata   = rd;
        #1;
        exp = (sb_b.size() != 0) ? sb_b.pop_front() : 3'd0;
        chk(tag, b_m_data_ok, exp);
    endtask

    initial begin
        resetn = 1'b0;
        a_m_req = '0; a_m_wr = 2'b10; a_m_size = 4'b1010; a_m_wstrb = 8'hF1;
        a_m_addr = {A1, A0}; a_m_wdata = {32'hDDDD_0001, 32'hCCCC_0000};
        a_s_addr_ok = 0; a_s_data_ok = 0; a_s_rdata = '0;
        b_m_req = '0; b_m_wr = '0; b_m_size = '0; b_m_wstrb = '0;
        b_m_addr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000}; b_m_wdata = '0;
        b_s_addr_ok = 0; b_s_data_ok = 0; b_s_rdata = '0;

        #2;
        chk("rst_s_req", a_s_req, 0);
        chk("rst_addr_ok", a_m_addr_ok, 0);
        chk("rst_data_ok", a_m_data_ok, 0);
        chk("rst_out", a_out, 0);
        chk("rst_err", a_err, 0);
        nxt(); resetn = 1'b1;

        // Fixed priority: highest index first
        nxt(); a_m_req = 2'b11; a_s_addr_ok = 1; sb_a.push_back(3'b010); #1;
        chk("prio_hi", a_m_addr_ok, 2'b10);
        chk("prio_addr", a_s_addr, A1);
        chk("prio_wr", a_s_wr, 1);
        chk("prio_wstrb", a_s_wstrb, 4'hF);
        nxt(); a_m_req = 2'b01; sb_a.push_back(3'b001); #1;
        chk("prio_lo", a_m_addr_ok, 2'b01);
        chk("prio_addr_lo", a_s_addr, A0);
        nxt(); a_m_req = 2'b00; a_s_addr_ok = 0; #1;
        chk("prio_out2", a_out, 2);
        chk("prio_idle", a_s_req, 0);
        nxt(); resp_a("prio_r0", 32'h11);
        nxt(); resp_a("prio_r1", 32'h22);
        nxt(); a_s_data_ok = 0; #1;
        chk("prio_out0", a_out, 0);

        // Stall lock: ch0 stalled, ch1 arrives, ch0 must stay granted
        nxt(); a_m_req = 2'b01; #1;
        chk("lock_s_req", a_s_req, 1);
        chk("lock_addr0", a_s_addr, A0);
        chk("lock_no_ok", a_m_addr_ok, 0);
        nxt(); a_m_req = 2'b11; #1;
        chk("lock_addr1", a_s_addr, A0);
        nxt(); #1;
        chk("lock_addr2", a_s_addr, A0);
        nxt(); a_s_addr_ok = 1; sb_a.push_back(3'b001); #1;
        chk("lock_acc0", a_m_addr_ok, 2'b01);
        chk("lock_acc_addr", a_s_addr, A0);
        nxt(); a_m_req = 2'b10; sb_a.push_back(3'b010); #1;
        chk("lock_acc1", a_m_addr_ok, 2'b10);
        nxt(); a_m_req = 2'b00; a_s_addr_ok = 0; resp_a("lock_r0", 32'h33);
        nxt(); resp_a("lock_r1", 32'h44);
        nxt(); a_s_data_ok = 0; #1;
        chk("lock_out0", a_out, 0);

        // Ordering and full: ch1,ch0,ch1,ch0
        for (int i = 0; i < 4; i++) begin
            nxt();
            a_m_req = (i % 2 == 0) ? 2'b10 : 2'b01;
            a_s_addr_ok = 1;
            sb_a.push_back((i % 2 == 0) ? 3'b010 : 3'b001);
            #1;
            chk("fill_ok", a_m_addr_ok, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        nxt(); a_m_req = 2'b01; #1;
        chk("full_s_req", a_s_req, 0);
        chk("full_no_ok", a_m_addr_ok, 0);
        chk("full_out", a_out, 4);
        a_s_addr_ok = 0;
        nxt(); resp_a("ord_rA", 32'hA);
        chk("full_no_bypass", a_m_addr_ok, 0);
        nxt(); resp_a("ord_rB", 32'hB);
        chk("reassert", a_s_req, 1);
        nxt(); resp_a("ord_rC", 32'hC);
        nxt(); resp_a("ord_rD", 32'hD);
        nxt(); a_s_data_ok = 0; a_m_req = 2'b00; #1;
        chk("ord_out0", a_out, 0);

        // Unexpected response with nothing outstanding
        nxt(); a_s_data_ok = 1; a_s_rdata = 32'hEE; #1;
        chk("unexp_no_data_ok", a_m_data_ok, 0);
        nxt(); a_s_data_ok = 0; #1;
        chk("unexp_err", a_err, 1);
        nxt(); #1;
        chk("unexp_sticky", a_err, 1);

        // Round-robin on B: all requesting, grants 0,1,2,0
        for (int i = 0; i < 4; i++) begin
            nxt(); b_m_req = 3'b111; b_s_addr_ok = 1;
            sb_b.push_back(3'b001 << (i % 3));
            #1;
            chk("rr_grant", b_m_addr_ok, 3'b001 << (i % 3));
        end
        nxt(); #1;
        chk("rr_full", b_s_req, 0);
        chk("rr_out", b_out, 4);
        b_m_req = 3'b000; b_s_addr_ok = 0;
        for (int i = 0; i < 4; i++) begin
            nxt(); resp_b("rr_resp", 32'(i));
        end
        nxt(); b_s_data_ok = 0; #1;
        chk("rr_out0", b_out, 0);

        // Reset mid-run with 3 outstanding
        for (int i = 0; i < 3; i++) begin
            nxt(); a_m_req = 2'b01; a_s_addr_ok = 1; sb_a.push_back(3'b001); #1;
            chk("pre_rst_ok", a_m_addr_ok, 2'b01);
        end
        nxt(); a_m_req = 2'b00; a_s_addr_ok = 0; #1;
        chk("pre_rst_out", a_out, 3);
        resetn = 1'b0; #1;
        sb_a.delete();
        chk("mid_rst_out", a_out, 0);
        chk("mid_rst_s_req", a_s_req, 0);
        chk("mid_rst_err", a_err, 0);
        nxt(); resetn = 1'b1; a_s_data_ok = 1; #1;
        chk("post_rst_no_data_ok", a_m_data_ok, 0);
        nxt(); a_s_data_ok = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
